// File: rtl/led_blink_pkg.sv
// Purpose : shared types and constants for the LED blink controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package led_blink_pkg;

    // Per-channel operating mode, encoded as written on the cfg bus.
    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_BURST = 2'd3
    } led_mode_t;

    // Width of the optional PWM dimming counter and duty registers.
    localparam int PWM_W = 8;

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Purpose : cfg write bus for led_blink_ctrl (valid/ready, one write per handshake).
// Latency : n/a (signal bundle only).
// Backpressure: master holds all fields stable while valid is high and ready is low.
//
// Signals : valid, ready, chan, mode, half, count
//           duty is present only when LED_BLINK_PWM_DIM_EN is defined.
// Modports: master (drives the write), slave (the controller).
interface led_blink_ctrl_if
    import led_blink_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int PER_W = 16,
    parameter int CNT_W = 8
) ();

    // Deliberately wider than strictly needed for some N_CH so that
    // out-of-range channel numbers can be presented and dropped.
    localparam int CH_W = $clog2(N_CH) | 1;

    logic             valid;
    logic             ready;
    logic [CH_W-1:0]  chan;
    led_mode_t        mode;
    logic [PER_W-1:0] half;
    logic [CNT_W-1:0] count;
`ifdef LED_BLINK_PWM_DIM_EN
    logic [PWM_W-1:0] duty;

    modport master (output valid, chan, mode, half, count, duty, input ready);
    modport slave  (input  valid, chan, mode, half, count, duty, output ready);
`else
    modport master (output valid, chan, mode, half, count, input ready);
    modport slave  (input  valid, chan, mode, half, count, output ready);
`endif

endinterface

// File: rtl/led_blink_chan.sv
// Purpose : one LED channel: OFF / ON / BLINK / counted BURST sequencer.
// Latency : a write takes effect on its own clock edge; toggles land on tick edges.
// Backpressure: none; a write strobe is always consumed and beats a coincident tick.
//
// Ports : clk, rst_n (async active-low)
//         tick        shared base tick, one cycle wide
//         wr          write strobe for this channel
//         mode/half/count  new configuration, sampled when wr is high
//         state_on    registered logical LED state (before dimming/polarity)
//         done        one-cycle pulse when a burst finishes
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int PER_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             wr,
    input  led_mode_t        mode,
    input  logic [PER_W-1:0] half,
    input  logic [CNT_W-1:0] count,
    output logic             state_on,
    output logic             done
);

    led_mode_t        cur_mode;
    logic [PER_W-1:0] half_q;
    logic [PER_W-1:0] phase;
    logic [CNT_W-1:0] remain;

    logic toggling;
    logic phase_end;

    assign toggling  = (cur_mode == LED_BLINK) || (cur_mode == LED_BURST);
    // half_q is never 0, so half_q-1 cannot wrap.
    assign phase_end = (phase == (half_q - PER_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_mode <= LED_OFF;
            half_q   <= PER_W'(1);
            phase    <= '0;
            remain   <= '0;
            state_on <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr) begin
                // A write restarts the channel; any in-flight burst is
                // abandoned silently and a coincident tick is discarded.
                cur_mode <= mode;
                half_q   <= (half == '0) ? PER_W'(1) : half;
                phase    <= '0;
                remain   <= count;
                unique case (mode)
                    LED_OFF:   state_on <= 1'b0;
                    LED_ON:    state_on <= 1'b1;
                    LED_BLINK: state_on <= 1'b1;
                    LED_BURST: begin
                        if (count == '0) begin
                            // Nothing to flash: finish on the write edge.
                            cur_mode <= LED_OFF;
                            state_on <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state_on <= 1'b1;
                        end
                    end
                    default:   state_on <= 1'b0;
                endcase
            end else if (tick && toggling) begin
                if (phase_end) begin
                    phase    <= '0;
                    state_on <= ~state_on;
                    // Bursts are counted on the on->off edge; the last one
                    // parks the channel in OFF (LED already going low here).
                    if ((cur_mode == LED_BURST) && state_on) begin
                        remain <= remain - CNT_W'(1);
                        if (remain == CNT_W'(1)) begin
                            cur_mode <= LED_OFF;
                            done     <= 1'b1;
                        end
                    end
                end else begin
                    phase <= phase + PER_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/led_blink_ctrl.sv
// Purpose : N-channel LED blink controller with shared tick prescaler and cfg bus.
// Latency : cfg write visible on o_led at the accepting edge; o_done is registered.
// Backpressure: o_cfg_ready is low only in the first cycle after reset, then always high.
//
// Ports : i_clk, i_rst_n (async active-low)
//         cfg    led_blink_ctrl_if.slave write bus (valid/ready/chan/mode/half/count[/duty])
//         o_led  LED pins, logical state XORed with ACT_LOW
//         o_done per-channel one-cycle burst-complete pulse
// Option: LED_BLINK_PWM_DIM_EN adds per-channel 8-bit duty dimming.
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1_000,
    parameter int N_CH    = 4,
    parameter int PER_W   = 16,
    parameter int CNT_W   = 8,
    parameter int ACT_LOW = 0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    led_blink_ctrl_if.slave    cfg,
    output logic [N_CH-1:0]    o_led,
    output logic [N_CH-1:0]    o_done
);

    // DIV must be at least 2 for the tick to be a single-cycle pulse.
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam int CH_W  = $clog2(N_CH) | 1;
    localparam logic ACT_BIT = (ACT_LOW != 0);

    // ---------------- prescaler ----------------
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    assign tick = (pre_cnt == PRE_W'(DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // ---------------- cfg handshake / decode ----------------
    logic            ready_q;
    logic            wr_fire;
    logic            chan_ok;
    logic [N_CH-1:0] wr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign cfg.ready = ready_q;
    assign wr_fire   = cfg.valid & ready_q;
    // Compare at 32 bits: for some N_CH the channel field cannot hold N_CH.
    assign chan_ok   = (32'(cfg.chan) < 32'(N_CH));

    // ---------------- channels ----------------
    logic [N_CH-1:0] state_on;

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        assign wr[c] = wr_fire & chan_ok & (cfg.chan == CH_W'(c));

        led_blink_chan #(
            .PER_W (PER_W),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk      (i_clk),
            .rst_n    (i_rst_n),
            .tick     (tick),
            .wr       (wr[c]),
            .mode     (cfg.mode),
            .half     (cfg.half),
            .count    (cfg.count),
            .state_on (state_on[c]),
            .done     (o_done[c])
        );
    end

`ifdef LED_BLINK_PWM_DIM_EN
    // ---------------- PWM dimming ----------------
    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W-1:0] duty [N_CH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pwm_cnt <= '0;
            for (int c = 0; c < N_CH; c++) begin
                duty[c] <= '1;
            end
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            for (int c = 0; c < N_CH; c++) begin
                if (wr[c]) begin
                    duty[c] <= cfg.duty;
                end
            end
        end
    end

    // Full-scale duty bypasses the compare so 8'hFF really means always on.
    for (genvar c = 0; c < N_CH; c++) begin : g_led
        assign o_led[c] = (state_on[c] & ((pwm_cnt < duty[c]) | (duty[c] == '1))) ^ ACT_BIT;
    end
`else
    assign o_led = state_on ^ {N_CH{ACT_BIT}};
`endif

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Purpose : directed self-checking bench for led_blink_ctrl (DIV=10, N_CH=4, ACT_LOW=0).
// Latency : checks sampled 1 time unit after each rising edge.
// Backpressure: cfg writes assume ready is high after the first post-reset edge.
module tb_led_blink_ctrl;
    import led_blink_pkg::*;

    logic i_clk;
    logic i_rst_n;
    logic [3:0] o_led;
    logic [3:0] o_done;

    int checks   = 0;
    int failures = 0;
    int cyc;          // rising edges since reset release
    int wedge;        // cyc value at the most recent write edge
    int n;
    int hi_cnt;
    logic exp_bit;
    logic exp_done;

    led_blink_ctrl_if #(.N_CH(4), .PER_W(16), .CNT_W(8)) cfg_if ();

    led_blink_ctrl #(
        .CLK_HZ  (1000),
        .TICK_HZ (100),
        .N_CH    (4),
        .PER_W   (16),
        .CNT_W   (8),
        .ACT_LOW (0)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .cfg     (cfg_if),
        .o_led   (o_led),
        .o_done  (o_done)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int ch, input led_mode_t m, input int h, input int c, input int d);
        cfg_if.chan  = 3'(ch);
        cfg_if.mode  = m;
        cfg_if.half  = 16'(h);
        cfg_if.count = 8'(c);
`ifdef LED_BLINK_PWM_DIM_EN
        cfg_if.duty  = 8'(d);
`else
        if (d < 0) $display("unused duty %0d", d);
`endif
        cfg_if.valid = 1'b1;
        step();
        cfg_if.valid = 1'b0;
        wedge = cyc;
    endtask

    // Leaves the bench one edge before a tick edge so the next write coincides with a tick.
    task automatic align_to_tick();
        for (int i = 0; i < 12 && (cyc % 10) != 9; i++) step();
    endtask

    initial begin
        i_rst_n      = 1'b0;
        cfg_if.valid = 1'b0;
        cfg_if.chan  = '0;
        cfg_if.mode  = LED_OFF;
        cfg_if.half  = '0;
        cfg_if.count = '0;
`ifdef LED_BLINK_PWM_DIM_EN
        cfg_if.duty  = 8'hFF;
`endif
        // ---- 1. reset values, ready after release ----
        #22;
        chk("rst_led",   o_led,        32'h0);
        chk("rst_done",  o_done,       32'h0);
        chk("rst_ready", cfg_if.ready, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        chk("ready_after_rel", cfg_if.ready, 32'h1);

        // ---- 2. ch0 BLINK half=3: on at write, toggles on tick edges 30,60,... ----
        wr(0, LED_BLINK, 3, 0, 255);
        chk("blink_write_edge", o_led, 32'h1);
        while (cyc < 602) begin
            step();
            exp_bit = ((cyc / 30) % 2) == 0;
            chk("blink_led", o_led, {31'b0, exp_bit});
            chk("blink_done", o_done, 32'h0);
        end
        wr(0, LED_OFF, 3, 0, 255);
        chk("ch0_off", o_led, 32'h0);

        // ---- 3. ch1 BURST half=2 count=3, written on a tick edge ----
        align_to_tick();
        wr(1, LED_BURST, 2, 3, 255);
        chk("burst_write_edge", o_led, 32'h2);
        hi_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            n = (cyc - wedge) / 10;
            exp_bit  = (n < 10) && (((n / 2) % 2) == 0);
            exp_done = (cyc - wedge) == 100;
            chk("burst_led",  o_led,  {30'b0, exp_bit, 1'b0});
            chk("burst_done", o_done, {30'b0, exp_done, 1'b0});
            if (o_done[1]) hi_cnt++;
        end
        chk("burst_done_count", hi_cnt, 32'd1);

        // ---- 4. count=0 burst and out-of-range channel ----
        wr(3, LED_ON, 1, 0, 255);
        chk("ch3_on", o_led, 32'h8);
        wr(2, LED_BURST, 5, 0, 255);
        chk("burst0_led",  o_led,  32'h8);
        chk("burst0_done", o_done, 32'h4);
        step();
        chk("burst0_done_gone", o_done, 32'h0);
        wr(5, LED_BLINK, 1, 1, 255);
        chk("ch5_ready", cfg_if.ready, 32'h1);
        chk("ch5_led",   o_led,        32'h8);
        for (int i = 0; i < 25; i++) step();
        chk("ch5_led_later", o_led,  32'h8);
        chk("ch5_done",      o_done, 32'h0);

        // ---- 5a. write ch0 on a tick edge: that tick is ignored ----
        align_to_tick();
        wr(0, LED_BLINK, 3, 0, 255);
        chk("tickwr_edge", o_led, 32'h9);
        for (int i = 0; i < 70; i++) begin
            step();
            exp_bit = (((cyc - wedge) / 30) % 2) == 0;
            chk("tickwr_led", o_led, {28'b0, 1'b1, 2'b0, exp_bit});
        end

        // ---- 5b. reset mid-burst ----
        wr(1, LED_BURST, 2, 3, 255);
        for (int i = 0; i < 5; i++) step();
        chk("preburst_led1", o_led[1], 32'h1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_led",   o_led,        32'h0);
        chk("midrst_done",  o_done,       32'h0);
        chk("midrst_ready", cfg_if.ready, 32'h0);
        for (int i = 0; i < 3; i++) step();
        chk("inrst_led",  o_led,  32'h0);
        chk("inrst_done", o_done, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        chk("ready_after_rel2", cfg_if.ready, 32'h1);
        // half=0 behaves as half=1; prescaler restarted so ticks fall on cyc 10,20,...
        wr(0, LED_BLINK, 0, 0, 255);
        chk("half0_edge", o_led, 32'h1);
        while (cyc < 40) begin
            step();
            exp_bit = ((cyc / 10) % 2) == 0;
            chk("half0_led", o_led, {31'b0, exp_bit});
        end

`ifdef LED_BLINK_PWM_DIM_EN
        // ---- 6. PWM dimming on ch3 ----
        wr(0, LED_OFF, 1, 0, 255);
        wr(3, LED_ON, 1, 0, 64);
        hi_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (o_led[3]) hi_cnt++;
        end
        chk("pwm_duty64", hi_cnt, 32'd64);
        wr(3, LED_ON, 1, 0, 255);
        hi_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (o_led[3]) hi_cnt++;
        end
        chk("pwm_dutyff", hi_cnt, 32'd256);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
